// File: rtl/efpga_ci_pkg.sv
// rtl/efpga_ci_pkg.sv - shared types and constants for the eFPGA custom-instruction responder
package efpga_ci_pkg;

  localparam int CI_DATA_W  = 32;
  localparam int CI_DELAY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

endpackage

// File: rtl/efpga_ci_delay_cnt.sv
// rtl/efpga_ci_delay_cnt.sv - loadable down-counter with zero flag for the fabric latency budget
module efpga_ci_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so a stray decrement can never wrap into a long wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/efpga_ci_responder.sv
// rtl/efpga_ci_responder.sv - launches a custom instruction into an eFPGA slot and returns its result
module efpga_ci_responder
  import efpga_ci_pkg::*;
#(
  parameter int DATA_W    = CI_DATA_W,
  parameter int DELAY_W   = CI_DELAY_W,
  parameter int MIN_DELAY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [1:0]         operator_i,
  input  logic [DATA_W-1:0]  operand_a_i,
  input  logic [DATA_W-1:0]  operand_b_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               ready_o,
  output logic [DATA_W-1:0]  result_o,
  output logic               fabric_start_o,
  output logic [3:0]         fabric_sel_o,
  output logic [DATA_W-1:0]  fabric_a_o,
  output logic [DATA_W-1:0]  fabric_b_o,
  input  logic [DATA_W-1:0]  fabric_result_i,
  input  logic               fabric_done_i,
  output logic               busy_o,
  output logic [31:0]        op_count_o
);

  localparam logic [DELAY_W-1:0] L_MIN_DELAY = DELAY_W'(MIN_DELAY);

  state_e             r_state;
  state_e             w_next;
  logic [1:0]         r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_result;
  logic               r_launch;
  logic [31:0]        r_op_count;
  logic [DELAY_W-1:0] w_delay_eff;
  logic               w_cnt_zero;
  logic               w_load;
  logic               w_dec;
  logic               w_capture;

  assign w_delay_eff = (delay_i < L_MIN_DELAY) ? L_MIN_DELAY : delay_i;

  efpga_ci_delay_cnt #(
    .W (DELAY_W)
  ) u_delay_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_delay_eff),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  // en_i low during RUN means the core flushed the instruction.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (en_i) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        if (!en_i) begin
          w_next = IDLE;
        end else if (w_cnt_zero || fabric_done_i) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_launch   <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state  <= w_next;
      r_launch <= w_load;
      if (w_load) begin
        r_op <= operator_i;
        r_a  <= operand_a_i;
        r_b  <= operand_b_i;
      end
      if (w_capture) begin
        r_result <= fabric_result_i;
      end
      if (r_state == DONE) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign ready_o        = (r_state == DONE);
  assign result_o       = ready_o ? r_result : '0;
  assign fabric_start_o = (r_state == RUN) && r_launch;
  assign fabric_sel_o   = (r_state == RUN) ? (4'b0001 << r_op) : 4'b0000;
  assign fabric_a_o     = r_a;
  assign fabric_b_o     = r_b;
  assign busy_o         = (r_state != IDLE);
  assign op_count_o     = r_op_count;

endmodule
